training_sample_feeder: RTL and testbench
=========================================

// Module: training_sample_feeder
// PURPOSE
//  Upstream stage of the 4-input / 2-hidden / 1-output training datapath.
//  Buffers up to DEPTH (x, target) training pairs loaded from the pads.
//  Replays them sample by sample for EPOCHS epochs, driving x/target/init into the network state machine.
//  Advances one sample per completed forward+backprop step.
// PARAMETERS
//  DEPTH   8   max stored samples (power of 2, >=2)
//  X_W     4   input-vector width (hidden_neuron x_i)
//  T_W     4   target width (output_neuron init_i)
//  EPOCHS  16  passes over the buffer before done (>=1)
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  async reset, active-low
//  en_i           in   1                  global enable; low = freeze all state
//  clear_i        in   1                  sync clear: empty buffer, go IDLE
//  load_valid_i   in   1                  load strobe
//  load_x_i       in   X_W                sample input vector
//  load_t_i       in   T_W                sample target
//  load_ready_o   out  1                  load accepted this cycle if valid
//  start_i        in   1                  begin training run
//  step_done_i    in   1                  pulse: network finished fwd+bp for current sample
//  init_o         out  1                  1-cycle pulse: start network on presented sample
//  sample_valid_o out  1                  x_o/target_o valid and stable
//  x_o            out  X_W                current sample input
//  target_o       out  T_W                current sample target
//  sample_idx_o   out  $clog2(DEPTH)      buffer index of current sample
//  count_o        out  $clog2(DEPTH+1)    samples stored
//  epoch_o        out  $clog2(EPOCHS)     current epoch, 0-based
//  busy_o / done_o out 1                  run in progress / run complete
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, count 0. Buffer contents are not reset and are masked by count.
//  All outputs registered. en_i low: state, counters, buffer held; load/start/step_done ignored.
//  Priority: clear_i > start_i > step_done_i.
//  IDLE:
//   load_ready_o = (count<DEPTH); write at addr count on valid&ready; count++.
//   start_i with count>0 -> ISSUE; idx=0, epoch=0. start_i with count==0 is ignored.
//   Load and start in the same cycle: the sample is written and included in the run.
//   Load while full: ignored, count holds at DEPTH.
//  ISSUE (1 cyc): init_o=1, sample_valid_o=1, busy_o=1 -> WAIT.
//   start_i registered at cycle N gives init_o high at N+1.
//  WAIT: sample_valid_o=1; x_o/target_o/idx held stable.
//   On step_done_i at cycle M:
//    - not last sample: idx++ (mod count) -> ISSUE at M+1, new x_o visible at M+1.
//    - last sample, epoch<EPOCHS-1: epoch++, idx=start offset -> ISSUE.
//    - last sample, epoch==EPOCHS-1 -> DONE.
//   step_done_i in IDLE/ISSUE/DONE: ignored.
//  DONE: done_o=1, busy_o=0, sample_valid_o=0, epoch_o holds EPOCHS-1.
//   start_i reruns from epoch 0 with the same buffer. Loads are not accepted (load_ready_o=0).
//  clear_i (any state): count=0, idx=0, epoch=0, -> IDLE next cycle. init_o is never asserted that cycle.
//  Reset mid-run: asynchronous return to reset values. Network sees sample_valid_o drop immediately.
//  Counters: idx wraps at count (not DEPTH); epoch never wraps.
// CONFIGURATION
//  FEEDER_ROTATE_EN defined:
//   Epoch e starts at idx = e mod count and visits count samples cyclically.
//   The "last sample" is the one before the start offset.
//  Undefined: every epoch runs idx 0..count-1.
// STRUCTURE
//  nn_pkg: feeder_state_t enum {IDLE,ISSUE,WAIT,DONE}; X_W/T_W widths shared with hidden/output neurons.
//  Sub-module sample_buffer: DEPTH x (X_W+T_W) register file, 1 sync write port, 1 async read port.
//  The FSM and counters live in this module.
// TESTING
//  1. Load 3 pairs (x=1,t=2),(x=3,t=4),(x=5,t=6); start; pulse step_done_i 3x
//     -> x_o sequence 1,3,5, idx 0,1,2, init_o one pulse per sample, epoch_o 0->1.
//  2. Load 8 samples then a 9th -> load_ready_o=0 after the 8th, count_o=8, 9th ignored.
//  3. EPOCHS=2, 2 samples, 4 step_done pulses -> done_o=1 after the 4th, epoch_o=1, sample_valid_o=0.
//  4. start_i with count=0 -> stays IDLE, init_o never asserted. Load+start in the same cycle -> count_o=1, run starts.
//  5. rst_i low mid-WAIT -> all outputs 0 immediately. clear_i in WAIT -> IDLE, count_o=0 next cycle.
//  6. FEEDER_ROTATE_EN, 3 samples, EPOCHS=3 -> idx order 0,1,2 | 1,2,0 | 2,0,1, then done_o.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and widths for the 4-input / 2-hidden / 1-output training datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

   // Widths shared with the hidden_neuron x_i inputs and output_neuron init_i target.
   localparam int NN_X_W = 4;
   localparam int NN_T_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } feeder_state_t;

   // Counter width that stays legal when a range collapses to a single value.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/training_sample_feeder_sample_buffer.sv
// Sample store: DEPTH x W register file, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write; read is combinational.
// Backpressure: none; the caller gates writes.
module sample_buffer #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_dat
);

   // Contents are deliberately not reset; the feeder masks stale entries with its count.
   logic [W-1:0] mem [DEPTH];

   // Write the incoming pair at the requested slot.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/training_sample_feeder.sv
// Buffers (x, target) pairs and replays them for EPOCHS epochs into the network FSM; FEEDER_ROTATE_EN rotates each epoch's start.
// Latency: start/step_done registered at cycle N -> init_o and new sample visible at N+1; all outputs registered.
// Backpressure: loads accepted only in IDLE while not full (load_ready_o); one sample advance per step_done_i pulse.
module training_sample_feeder
   import nn_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int X_W    = NN_X_W,
   parameter int T_W    = NN_T_W,
   parameter int EPOCHS = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          clear_i,
   input  logic                          load_valid_i,
   input  logic [X_W-1:0]                load_x_i,
   input  logic [T_W-1:0]                load_t_i,
   output logic                          load_ready_o,
   input  logic                          start_i,
   input  logic                          step_done_i,
   output logic                          init_o,
   output logic                          sample_valid_o,
   output logic [X_W-1:0]                x_o,
   output logic [T_W-1:0]                target_o,
   output logic [$clog2(DEPTH)-1:0]      sample_idx_o,
   output logic [$clog2(DEPTH+1)-1:0]    count_o,
   output logic [width_of(EPOCHS)-1:0]   epoch_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = width_of(EPOCHS);
   localparam int DW = X_W + T_W;
   localparam logic [CW-1:0] FULL       = CW'(DEPTH);
   localparam logic [EW-1:0] LAST_EPOCH = EW'(EPOCHS - 1);

   feeder_state_t state;
   logic [IW-1:0] base;        // index at which the current epoch began
   logic          load_fire;
   logic          start_ok;
   logic          step_ok;
   logic          is_last;
   logic [CW-1:0] run_cnt;
   logic [CW-1:0] last_pos;
   logic [CW-1:0] idx_ext;
   logic [IW-1:0] wrap_idx;
   logic [IW-1:0] next_base;
   logic [IW-1:0] rd_addr;
   logic [DW-1:0] wr_dat;
   logic [DW-1:0] buf_dat;
   logic [DW-1:0] rd_dat;

   sample_buffer #(
      .DEPTH (DEPTH),
      .W     (DW)
   ) u_buffer (
      .clk     (clk_i),
      .wr_en   (load_fire),
      .wr_addr (count_o[IW-1:0]),
      .wr_dat  (wr_dat),
      .rd_addr (rd_addr),
      .rd_dat  (buf_dat)
   );

   // Handshake qualification, index arithmetic and the address of the sample to present next.
   always_comb begin
      wr_dat    = {load_x_i, load_t_i};
      load_fire = en_i && !clear_i && (state == IDLE) && load_valid_i && load_ready_o;
      run_cnt   = count_o + CW'(load_fire);
      start_ok  = en_i && !clear_i && start_i &&
                  (((state == IDLE) && (run_cnt != '0)) || (state == DONE));
      step_ok   = en_i && !clear_i && step_done_i && (state == WAIT);
      idx_ext   = CW'(sample_idx_o);
      // The epoch ends on the sample just before the one it started from.
      last_pos  = (base == '0) ? (count_o - CW'(1)) : (CW'(base) - CW'(1));
      is_last   = (idx_ext == last_pos);
      // Wrap at the stored count, not at DEPTH.
      wrap_idx  = (idx_ext == (count_o - CW'(1))) ? '0 : (sample_idx_o + IW'(1));
`ifdef FEEDER_ROTATE_EN
      next_base = (CW'(base) == (count_o - CW'(1))) ? '0 : (base + IW'(1));
`else
      next_base = '0;
`endif
      if (start_ok) begin
         rd_addr = '0;
      end else if (step_ok && !is_last) begin
         rd_addr = wrap_idx;
      end else if (step_ok) begin
         rd_addr = next_base;
      end else begin
         rd_addr = sample_idx_o;
      end
      // A pair loaded in the same cycle as start is not in the array yet; forward it.
      rd_dat = (load_fire && (rd_addr == count_o[IW-1:0])) ? wr_dat : buf_dat;
   end

   // Feeder FSM with counters and registered outputs; en_i low freezes everything.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= IDLE;
         base           <= '0;
         load_ready_o   <= 1'b0;
         init_o         <= 1'b0;
         sample_valid_o <= 1'b0;
         x_o            <= '0;
         target_o       <= '0;
         sample_idx_o   <= '0;
         count_o        <= '0;
         epoch_o        <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else if (en_i) begin
         init_o <= 1'b0;
         if (clear_i) begin
            state          <= IDLE;
            base           <= '0;
            load_ready_o   <= 1'b1;
            sample_valid_o <= 1'b0;
            x_o            <= '0;
            target_o       <= '0;
            sample_idx_o   <= '0;
            count_o        <= '0;
            epoch_o        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
         end else if (start_ok) begin
            state          <= ISSUE;
            base           <= '0;
            load_ready_o   <= 1'b0;
            init_o         <= 1'b1;
            sample_valid_o <= 1'b1;
            x_o            <= rd_dat[DW-1:T_W];
            target_o       <= rd_dat[T_W-1:0];
            sample_idx_o   <= '0;
            count_o        <= run_cnt;
            epoch_o        <= '0;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  count_o      <= run_cnt;
                  load_ready_o <= (run_cnt < FULL);
               end
               ISSUE: begin
                  state <= WAIT;
               end
               WAIT: begin
                  if (step_ok) begin
                     if (!is_last || (epoch_o != LAST_EPOCH)) begin
                        state        <= ISSUE;
                        init_o       <= 1'b1;
                        x_o          <= rd_dat[DW-1:T_W];
                        target_o     <= rd_dat[T_W-1:0];
                        sample_idx_o <= rd_addr;
                        if (is_last) begin
                           epoch_o <= epoch_o + EW'(1);
                           base    <= next_base;
                        end
                     end else begin
                        state          <= DONE;
                        sample_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_training_sample_feeder.sv
// Directed bench for training_sample_feeder: two instances (EPOCHS=2 and EPOCHS=3) share stimulus.
// Expected samples are queued at start and compared on every init_o pulse.
// Honours FEEDER_ROTATE_EN when computing the expected visiting order.
`timescale 1ns/1ps
module tb_training_sample_feeder;

   localparam int DEPTH = 8;
`ifdef FEEDER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       en         = 1'b0;
   logic       clear      = 1'b0;
   logic       load_valid = 1'b0;
   logic       start      = 1'b0;
   logic       step_done  = 1'b0;
   logic [3:0] load_x     = '0;
   logic [3:0] load_t     = '0;

   logic       a_ready, a_init, a_sv, a_busy, a_done;
   logic [3:0] a_x, a_t, a_cnt;
   logic [2:0] a_idx;
   logic [0:0] a_ep;
   logic       b_ready, b_init, b_sv, b_busy, b_done;
   logic [3:0] b_x, b_t, b_cnt;
   logic [2:0] b_idx;
   logic [1:0] b_ep;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] x;
      logic [3:0] t;
      logic [1:0] ep;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [3:0] mx [DEPTH];
   logic [3:0] mt [DEPTH];
   int  mcount  = 0;
   bit  mon_a   = 1'b0;
   bit  mon_b   = 1'b0;
   int  a_inits = 0;
   int  b_inits = 0;

   training_sample_feeder #(.DEPTH(DEPTH), .X_W(4), .T_W(4), .EPOCHS(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
      .load_valid_i(load_valid), .load_x_i(load_x), .load_t_i(load_t), .load_ready_o(a_ready),
      .start_i(start), .step_done_i(step_done), .init_o(a_init), .sample_valid_o(a_sv),
      .x_o(a_x), .target_o(a_t), .sample_idx_o(a_idx), .count_o(a_cnt), .epoch_o(a_ep),
      .busy_o(a_busy), .done_o(a_done)
   );

   training_sample_feeder #(.DEPTH(DEPTH), .X_W(4), .T_W(4), .EPOCHS(3)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
      .load_valid_i(load_valid), .load_x_i(load_x), .load_t_i(load_t), .load_ready_o(b_ready),
      .start_i(start), .step_done_i(step_done), .init_o(b_init), .sample_valid_o(b_sv),
      .x_o(b_x), .target_o(b_t), .sample_idx_o(b_idx), .count_o(b_cnt), .epoch_o(b_ep),
      .busy_o(b_busy), .done_o(b_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop for instance A on each init pulse.
   always @(negedge clk) begin
      if (mon_a && a_init) begin
         a_inits++;
         if (qa.size() == 0) begin
            chk("a_extra_init", 32'(a_init), 32'd0);
         end else begin
            ea = qa.pop_front();
            chk("a_idx", 32'(a_idx), 32'(ea.idx));
            chk("a_x", 32'(a_x), 32'(ea.x));
            chk("a_t", 32'(a_t), 32'(ea.t));
            chk("a_epoch", 32'(a_ep), 32'(ea.ep));
            chk("a_valid", 32'(a_sv), 32'd1);
            chk("a_busy", 32'(a_busy), 32'd1);
         end
      end
   end

   // Scoreboard pop for instance B on each init pulse.
   always @(negedge clk) begin
      if (mon_b && b_init) begin
         b_inits++;
         if (qb.size() == 0) begin
            chk("b_extra_init", 32'(b_init), 32'd0);
         end else begin
            eb = qb.pop_front();
            chk("b_idx", 32'(b_idx), 32'(eb.idx));
            chk("b_x", 32'(b_x), 32'(eb.x));
            chk("b_t", 32'(b_t), 32'(eb.t));
            chk("b_epoch", 32'(b_ep), 32'(eb.ep));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_one(input logic [3:0] x, input logic [3:0] t);
      load_valid = 1'b1;
      load_x     = x;
      load_t     = t;
      cyc();
      load_valid = 1'b0;
      if (mcount < DEPTH) begin
         mx[mcount] = x;
         mt[mcount] = t;
         mcount++;
      end
   endtask

   task automatic push_run(input int epochs, input bit to_b);
      for (int e = 0; e < epochs; e++) begin
         int off;
         off = ROT ? (e % mcount) : 0;
         for (int k = 0; k < mcount; k++) begin
            int   i;
            exp_t s;
            i     = (off + k) % mcount;
            s.idx = 3'(i);
            s.x   = mx[i];
            s.t   = mt[i];
            s.ep  = 2'(e);
            if (to_b) qb.push_back(s);
            else      qa.push_back(s);
         end
      end
   endtask

   task automatic run_start(input bit pa, input bit pb);
      if (pa) push_run(2, 1'b0);
      if (pb) push_run(3, 1'b1);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic step();
      cyc();
      step_done = 1'b1;
      cyc();
      step_done = 1'b0;
   endtask

   task automatic do_clear();
      qa.delete();
      qb.delete();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      mcount = 0;
   endtask

   initial begin
      // Reset values
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(a_ready), 0);
      chk("rst_init", 32'(a_init), 0);
      chk("rst_valid", 32'(a_sv), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_count", 32'(a_cnt), 0);
      chk("rst_idx", 32'(a_idx), 0);
      chk("rst_epoch", 32'(a_ep), 0);
      chk("rst_x", 32'(a_x), 0);
      rst = 1'b1;
      en  = 1'b1;
      cyc();
      chk("ready_after_rst", 32'(a_ready), 1);

      // 1: three pairs, one full run of 2 epochs
      mon_a = 1'b1;
      load_one(4'd1, 4'd2);
      load_one(4'd3, 4'd4);
      load_one(4'd5, 4'd6);
      chk("t1_count", 32'(a_cnt), 3);
      run_start(1'b1, 1'b0);
      chk("t1_busy", 32'(a_busy), 1);
      repeat (3) step();
      chk("t1_epoch1", 32'(a_ep), 1);
      chk("t1_epoch1_idx", 32'(a_idx), ROT ? 32'd1 : 32'd0);
      repeat (3) step();
      chk("t1_done", 32'(a_done), 1);
      chk("t1_valid", 32'(a_sv), 0);
      chk("t1_busy_end", 32'(a_busy), 0);
      chk("t1_inits", 32'(a_inits), 6);
      chk("t1_queue", 32'(qa.size()), 0);

      // 2: fill to DEPTH, ninth load ignored
      do_clear();
      chk("t2_clear_count", 32'(a_cnt), 0);
      chk("t2_ready", 32'(a_ready), 1);
      for (int i = 0; i < 8; i++) load_one(4'(i + 8), 4'(15 - i));
      chk("t2_full_ready", 32'(a_ready), 0);
      chk("t2_count8", 32'(a_cnt), 8);
      load_one(4'h3, 4'h3);
      chk("t2_count_hold", 32'(a_cnt), 8);
      a_inits = 0;
      run_start(1'b1, 1'b0);
      repeat (16) step();
      chk("t2_done", 32'(a_done), 1);
      chk("t2_inits", 32'(a_inits), 16);
      chk("t2_queue", 32'(qa.size()), 0);

      // 3: two samples, freeze, done, ignored step/load, rerun
      do_clear();
      load_one(4'd2, 4'd9);
      load_one(4'd6, 4'd1);
      run_start(1'b1, 1'b0);
      cyc();
      en        = 1'b0;
      step_done = 1'b1;
      cyc();
      cyc();
      en        = 1'b1;
      step_done = 1'b0;
      chk("t3_freeze_idx", 32'(a_idx), 0);
      chk("t3_freeze_x", 32'(a_x), 2);
      chk("t3_freeze_valid", 32'(a_sv), 1);
      repeat (4) step();
      chk("t3_done", 32'(a_done), 1);
      chk("t3_epoch", 32'(a_ep), 1);
      chk("t3_valid", 32'(a_sv), 0);
      chk("t3_busy", 32'(a_busy), 0);
      chk("t3_ready_done", 32'(a_ready), 0);
      step();
      chk("t3_done_hold", 32'(a_done), 1);
      load_valid = 1'b1;
      load_x     = 4'hF;
      cyc();
      load_valid = 1'b0;
      chk("t3_load_in_done", 32'(a_cnt), 2);
      run_start(1'b1, 1'b0);
      chk("t3_rerun_epoch", 32'(a_ep), 0);
      chk("t3_rerun_done", 32'(a_done), 0);
      repeat (4) step();
      chk("t3_rerun_end", 32'(a_done), 1);
      chk("t3_queue", 32'(qa.size()), 0);

      // 4: start on empty buffer, then load+start together
      do_clear();
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("t4_empty_busy", 32'(a_busy), 0);
      chk("t4_empty_init", 32'(a_init), 0);
      cyc();
      chk("t4_empty_idle", 32'(a_sv), 0);
      mx[0]  = 4'd7;
      mt[0]  = 4'd3;
      mcount = 1;
      push_run(2, 1'b0);
      load_valid = 1'b1;
      load_x     = 4'd7;
      load_t     = 4'd3;
      start      = 1'b1;
      cyc();
      load_valid = 1'b0;
      start      = 1'b0;
      chk("t4_count", 32'(a_cnt), 1);
      chk("t4_busy", 32'(a_busy), 1);
      chk("t4_init", 32'(a_init), 1);
      repeat (2) step();
      chk("t4_done", 32'(a_done), 1);
      chk("t4_queue", 32'(qa.size()), 0);

      // 5: reset mid-WAIT, then clear mid-WAIT
      do_clear();
      load_one(4'd4, 4'd5);
      load_one(4'd6, 4'd7);
      run_start(1'b1, 1'b0);
      cyc();
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(a_sv), 0);
      chk("t5_rst_busy", 32'(a_busy), 0);
      chk("t5_rst_init", 32'(a_init), 0);
      chk("t5_rst_count", 32'(a_cnt), 0);
      chk("t5_rst_x", 32'(a_x), 0);
      qa.delete();
      mcount = 0;
      #10 rst = 1'b1;
      cyc();
      load_one(4'd4, 4'd5);
      load_one(4'd6, 4'd7);
      run_start(1'b1, 1'b0);
      cyc();
      qa.delete();
      clear     = 1'b1;
      step_done = 1'b1;
      cyc();
      clear     = 1'b0;
      step_done = 1'b0;
      mcount    = 0;
      chk("t5_clr_count", 32'(a_cnt), 0);
      chk("t5_clr_busy", 32'(a_busy), 0);
      chk("t5_clr_valid", 32'(a_sv), 0);
      chk("t5_clr_init", 32'(a_init), 0);
      chk("t5_clr_ready", 32'(a_ready), 1);
      cyc();

      // 6: three samples on both instances (EPOCHS 2 and 3)
      do_clear();
      mon_b = 1'b1;
      load_one(4'd7, 4'd1);
      load_one(4'd8, 4'd2);
      load_one(4'd9, 4'd3);
      run_start(1'b1, 1'b1);
      repeat (9) step();
      chk("t6_b_done", 32'(b_done), 1);
      chk("t6_b_epoch", 32'(b_ep), 2);
      chk("t6_b_valid", 32'(b_sv), 0);
      chk("t6_b_inits", 32'(b_inits), 9);
      chk("t6_b_queue", 32'(qb.size()), 0);
      chk("t6_a_done", 32'(a_done), 1);
      chk("t6_a_queue", 32'(qa.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
